// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mult_pkg;

  // Controller states: wait for a request, retire digits, publish the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Digit widths the step datapath is built and checked for.
  localparam int STEP_SMALL  = 1;
  localparam int STEP_MEDIUM = 2;
  localparam int STEP_LARGE  = 4;

  // True when the WIDTH/STEP pair is one the datapath supports.
  function automatic bit params_ok(input int width, input int step);
    bit step_legal;
    step_legal = (step == STEP_SMALL) || (step == STEP_MEDIUM) || (step == STEP_LARGE);
    return step_legal && (width >= 4) && ((width % 2) == 0) && ((width % step) == 0);
  endfunction

  // Bits needed for a step counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add digit: add digit*multiplicand into the accumulator, then
// shift the {acc,mplr} pair right by STEP. The sum is kept WIDTH+STEP bits
// wide so the carry out of the add lands in the upper accumulator bits.
module seq_mult_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mplr,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mplr
);

  logic [WIDTH+STEP-1:0] w_partial;
  logic [WIDTH+STEP-1:0] w_sum;

  // digit < 2^STEP and mcand < 2^WIDTH, so the partial fits WIDTH+STEP bits
  assign w_partial = (WIDTH+STEP)'(i_mplr[STEP-1:0]) * (WIDTH+STEP)'(i_mcand);
  assign w_sum     = (WIDTH+STEP)'(i_acc) + w_partial;
  assign o_acc     = w_sum[WIDTH+STEP-1:STEP];

  if (STEP < WIDTH) begin : g_shift_in
    assign o_mplr = {w_sum[STEP-1:0], i_mplr[WIDTH-1:STEP]};
  end else begin : g_full_digit
    assign o_mplr = w_sum[STEP-1:0];
  end

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier (MUL/MULT/MULTU) for the EX stage.
// Operands are reduced to magnitudes on capture; the sign is reapplied to
// the full 2*WIDTH product in the FIN cycle, so -2^(W-1) needs no special case.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_width(N);

  if (!params_ok(WIDTH, STEP)) begin : g_bad_cfg
    $error("seq_mult: unsupported WIDTH/STEP combination");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_mplr;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_z;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_neg;
  logic                 w_last;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic [WIDTH-1:0]     w_mplr_nxt;
  logic [2*WIDTH-1:0]   w_prod_raw;
  logic [2*WIDTH-1:0]   w_product;

  // Magnitudes: two's-complement negate only for negative signed operands.
  // For -2^(W-1) the negation wraps back to 2^(W-1), the correct unsigned magnitude.
  assign w_mag_a = (sign_mode && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
  assign w_mag_b = (sign_mode && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
  assign w_neg   = sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_last  = (r_cnt == CW'(N - 1));

  assign w_prod_raw = {r_acc, r_mplr};
  assign w_product  = r_neg ? (~w_prod_raw + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_prod_raw;

  seq_mult_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_acc   (r_acc),
    .i_mplr  (r_mplr),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_nxt),
    .o_mplr  (w_mplr_nxt)
  );

  // Next-state logic: accept in IDLE, retire N digits in RUN, publish in FIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; z only moves on the FIN edge or reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc   <= '0;
      r_mplr  <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= w_mag_a;
            r_mplr  <= w_mag_b;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_acc  <= w_acc_nxt;
          r_mplr <= w_mplr_nxt;
          r_cnt  <= r_cnt + CW'(1);
        end
        FIN: begin
          r_z    <= w_product;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign z    = r_z;
  assign busy = r_busy;
  assign done = r_done;

endmodule
